// File: rtl/uart_rx_sampler.sv
// 16x-oversampled UART receiver: 8N1 by default.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits (8E1).
module uart_rx_sampler #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int OVS     = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam int SW = $clog2(OVS);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    state_t          state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic [DBIT-1:0] dout_next;
    logic            done_next;
    logic            ferr_next;
    logic            rx_meta, rx_s;

`ifdef UART_RX_PARITY_EN
    logic            p, p_next;
    logic            perr_reg, perr_next;
`endif

    // Stages reset high so a reset release never looks like a start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p            <= 1'b0;
            perr_reg     <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            s            <= s_next;
            n            <= n_next;
            b            <= b_next;
            dout         <= dout_next;
            rx_done_tick <= done_next;
            frame_err    <= ferr_next;
`ifdef UART_RX_PARITY_EN
            p            <= p_next;
            perr_reg     <= perr_next;
`endif
        end
    end

    // Result registers are loaded only at the final stop tick, so they hold between frames.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        dout_next  = dout;
        done_next  = 1'b0;
        ferr_next  = frame_err;
`ifdef UART_RX_PARITY_EN
        p_next     = p;
        perr_next  = perr_reg;
`endif

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
`ifdef UART_RX_PARITY_EN
                            p_next     = 1'b0;
`endif
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
`ifdef UART_RX_PARITY_EN
                        p_next = p ^ rx_s;
`endif
                        if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            // Folding the parity bit into the accumulator leaves 1 exactly on a mismatch.
            PARITY: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        p_next     = p ^ rx_s;
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
`endif

            STOP: begin
                if (s_tick) begin
                    if (s == S_STOP) begin
                        dout_next  = b;
                        ferr_next  = ~rx_s;
                        done_next  = 1'b1;
                        state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_next  = p;
`endif
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed self-checking bench for uart_rx_sampler using a 13-clock tick generator.
// Builds with or without UART_RX_PARITY_EN; parity vectors run only when it is defined.
module tb_uart_rx_sampler;

    localparam int TICK_DIV = 13;
    localparam int BIT_CLK  = 16 * TICK_DIV;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int FRAME_CLK = (NB + 2) * BIT_CLK;

    logic       clock = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    int         tickCnt   = 0;
    int         cycle     = 0;
    int         doneCount = 0;
    int         doneWide  = 0;
    logic       prevDone  = 1'b0;
    int         doneCycles[$];
    logic [7:0] doneData[$];

    int checks   = 0;
    int failures = 0;
    int expDone  = 0;
    int cntBefore;

    uart_rx_sampler #(
        .DBIT(8),
        .SB_TICK(16),
        .OVS(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .s_tick(s_tick),
        .rx(rx),
        .dout(dout),
        .rx_done_tick(rx_done_tick),
        .frame_err(frame_err),
        .parity_err(parity_err)
    );

    always #10 clock = ~clock;

    always @(posedge clock) begin
        tickCnt <= (tickCnt == TICK_DIV - 1) ? 0 : tickCnt + 1;
        cycle   <= cycle + 1;
    end

    assign s_tick = (tickCnt == TICK_DIV - 1);

    // Records every done pulse with its cycle and data, and flags pulses wider than one clock.
    always @(negedge clock) begin
        prevDone <= rx_done_tick;
        if (rx_done_tick) begin
            doneCount <= doneCount + 1;
            doneCycles.push_back(cycle);
            doneData.push_back(dout);
            if (prevDone) doneWide <= doneWide + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveLevel(input logic level, input int clocks);
        rx = level;
        repeat (clocks) @(negedge clock);
    endtask

    function automatic logic [8:0] frameOf(input logic [7:0] d);
        return {^d, d};
    endfunction

    // A bad stop bit is held low past its mid-bit sample, then released so the rearmed receiver sees a glitch.
    task automatic applyStimulus(input logic [8:0] payload, input logic stopOk, input int idleBits);
        driveLevel(1'b0, BIT_CLK);
        for (int i = 0; i < NB; i++) driveLevel(payload[i], BIT_CLK);
        if (stopOk) begin
            driveLevel(1'b1, BIT_CLK);
        end else begin
            driveLevel(1'b0, (3 * BIT_CLK) / 4);
            driveLevel(1'b1, BIT_CLK - (3 * BIT_CLK) / 4);
        end
        driveLevel(1'b1, idleBits * BIT_CLK);
    endtask

    initial begin
        rx    = 1'b1;
        reset = 1'b1;
        #5 reset = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("rstDout", dout, 32'h0);
        checkOutput("rstDone", rx_done_tick, 32'h0);
        checkOutput("rstFerr", frame_err, 32'h0);
        checkOutput("rstPerr", parity_err, 32'h0);
        reset = 1'b1;
        driveLevel(1'b1, 2 * BIT_CLK);

        applyStimulus(frameOf(8'hA5), 1'b1, 1);
        expDone++;
        checkOutput("a5Count", doneCount, expDone);
        checkOutput("a5Dout", dout, 32'hA5);
        checkOutput("a5Ferr", frame_err, 32'h0);
        checkOutput("a5Perr", parity_err, 32'h0);

        driveLevel(1'b0, 4 * TICK_DIV);
        driveLevel(1'b1, 2 * BIT_CLK);
        checkOutput("glitchCount", doneCount, expDone);
        checkOutput("glitchDout", dout, 32'hA5);
        checkOutput("glitchIdle", int'(dut.state), 32'h0);

        applyStimulus(frameOf(8'h3C), 1'b0, 2);
        expDone++;
        checkOutput("badStopCount", doneCount, expDone);
        checkOutput("badStopDout", dout, 32'h3C);
        checkOutput("badStopFerr", frame_err, 32'h1);

        applyStimulus(frameOf(8'h81), 1'b1, 1);
        expDone++;
        checkOutput("goodCount", doneCount, expDone);
        checkOutput("goodDout", dout, 32'h81);
        checkOutput("goodFerr", frame_err, 32'h0);

        applyStimulus(frameOf(8'h00), 1'b1, 0);
        applyStimulus(frameOf(8'hFF), 1'b1, 1);
        expDone += 2;
        checkOutput("b2bCount", doneCount, expDone);
        checkOutput("b2bSpacing", doneCycles[$] - doneCycles[$-1], FRAME_CLK);
        checkOutput("b2bFirst", doneData[$-1], 32'h00);
        checkOutput("b2bSecond", doneData[$], 32'hFF);

        cntBefore = doneCount;
        fork
            applyStimulus(frameOf(8'h55), 1'b1, 0);
            begin
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clock);
                reset = 1'b0;
                #1;
                checkOutput("abortDout", dout, 32'h0);
                checkOutput("abortDone", rx_done_tick, 32'h0);
                checkOutput("abortFerr", frame_err, 32'h0);
                checkOutput("abortPerr", parity_err, 32'h0);
            end
        join
        driveLevel(1'b1, BIT_CLK);
        reset = 1'b1;
        driveLevel(1'b1, BIT_CLK);
        checkOutput("abortNoDone", doneCount, cntBefore);

        applyStimulus(frameOf(8'h55), 1'b1, 1);
        expDone = cntBefore + 1;
        checkOutput("recoverCount", doneCount, expDone);
        checkOutput("recoverDout", dout, 32'h55);
        checkOutput("recoverFerr", frame_err, 32'h0);

`ifdef UART_RX_PARITY_EN
        applyStimulus({1'b1, 8'h01}, 1'b1, 1);
        checkOutput("parGoodPerr", parity_err, 32'h0);
        checkOutput("parGoodDout", dout, 32'h01);
        applyStimulus({1'b0, 8'h01}, 1'b1, 1);
        checkOutput("parBadPerr", parity_err, 32'h1);
        checkOutput("parBadDout", dout, 32'h01);
`endif

        checkOutput("doneWidth", doneWide, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
